// File: rtl/sim_run_ctrl.sv
// ============================================================================
// Module  : sim_run_ctrl
// Purpose : Emulation run controller. Sequences DUT reset release, keeps the
//           global cycle count, runs a commit watchdog and gates the trace
//           window. Optional feature macro: T1_TRACE_WINDOW_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_run_ctrl #(
    parameter int RESET_CYCLES = 5,
    parameter int CYCLE_W      = 64,
    parameter int TIMEOUT_W    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CYCLE_W-1:0]   cfg_dump_start,
    input  logic [CYCLE_W-1:0]   cfg_dump_end,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 commit_valid,
    input  logic                 finish_req,
    output logic                 core_reset,
    output logic [CYCLE_W-1:0]   cycle,
    output logic                 trace_on,
    output logic                 timeout_fire,
    output logic                 sim_done,
    output logic [1:0]           status
);

    localparam int                  c_HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESET_CYCLES - 1);
    localparam logic [1:0]          c_ST_NONE   = 2'd0;
    localparam logic [1:0]          c_ST_REQ    = 2'd1;
    localparam logic [1:0]          c_ST_TMO    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_TMO  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_HOLD_W-1:0]    r_hold_cnt;
    logic [TIMEOUT_W-1:0]   r_wd_cnt;
    logic [TIMEOUT_W-1:0]   r_timeout;
    logic [CYCLE_W-1:0]     r_cycle;
    logic                   r_core_reset;
    logic                   r_timeout_fire;
    logic                   r_sim_done;
    logic [1:0]             r_status;

    logic                   w_cycle_active;
    logic [CYCLE_W-1:0]     w_cycle_next;
    logic                   w_wd_expire;
    logic                   w_end_hit;
    logic [1:0]             w_status_next;
    logic                   w_fire_next;
    logic                   w_terminal_next;

    assign w_cycle_active  = (r_state == ST_HOLD) || (r_state == ST_RUN);
    assign w_cycle_next    = (w_cycle_active && (r_cycle != '1)) ? r_cycle + CYCLE_W'(1) : r_cycle;
    assign w_wd_expire     = (r_timeout != '0) && (r_wd_cnt == r_timeout - TIMEOUT_W'(1)) && !commit_valid;
    assign w_terminal_next = (w_state_next == ST_DONE) || (w_state_next == ST_TMO);

`ifdef T1_TRACE_WINDOW_EN
    logic [CYCLE_W-1:0]     r_dump_start;
    logic [CYCLE_W-1:0]     r_dump_end;
    logic [CYCLE_W-1:0]     w_start_eff;
    logic [CYCLE_W-1:0]     w_end_eff;
    logic                   w_trace_next;
    logic                   r_trace_on;

    // On the latching edge the registers still hold stale bounds, so use the live inputs.
    assign w_start_eff  = (r_state == ST_IDLE) ? cfg_dump_start : r_dump_start;
    assign w_end_eff    = (r_state == ST_IDLE) ? cfg_dump_end   : r_dump_end;
    assign w_end_hit    = (r_dump_end != '0) && (w_cycle_next >= r_dump_end);
    assign w_trace_next = ((w_state_next == ST_HOLD) || (w_state_next == ST_RUN))
                        && (w_cycle_next >= w_start_eff)
                        && ((w_end_eff == '0) || (w_cycle_next < w_end_eff));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dump_start <= '0;
            r_dump_end   <= '0;
            r_trace_on   <= 1'b0;
        end else begin
            r_trace_on <= w_trace_next;
            if (r_state == ST_IDLE) begin
                r_dump_start <= cfg_dump_start;
                r_dump_end   <= cfg_dump_end;
            end
        end
    end

    assign trace_on = r_trace_on;
`else
    logic w_unused_dump;

    assign w_unused_dump = ^{cfg_dump_start, cfg_dump_end};
    assign w_end_hit     = 1'b0;
    assign trace_on      = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        w_fire_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // An orderly end outranks a watchdog expiry on the same edge.
                if (finish_req || w_end_hit) begin
                    w_state_next  = ST_DONE;
                    w_status_next = c_ST_REQ;
                end else if (w_wd_expire) begin
                    w_state_next  = ST_TMO;
                    w_status_next = c_ST_TMO;
                    w_fire_next   = 1'b1;
                end
            end
            ST_DONE, ST_TMO: begin
                w_state_next = r_state;
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_status_next = c_ST_NONE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold_cnt     <= '0;
            r_wd_cnt       <= '0;
            r_timeout      <= '0;
            r_cycle        <= '0;
            r_core_reset   <= 1'b1;
            r_timeout_fire <= 1'b0;
            r_sim_done     <= 1'b0;
            r_status       <= c_ST_NONE;
        end else begin
            r_cycle        <= w_cycle_next;
            // DUT reset follows the current state, so it drops one edge after RUN entry.
            r_core_reset   <= (r_state != ST_RUN);
            r_timeout_fire <= w_fire_next;
            r_sim_done     <= w_terminal_next;
            r_status       <= w_status_next;

            if (r_state == ST_IDLE) begin
                r_timeout  <= cfg_timeout;
                r_hold_cnt <= '0;
            end else if ((r_state == ST_HOLD) && (r_hold_cnt != c_HOLD_LAST)) begin
                r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
            end

            if ((r_state != ST_RUN) || commit_valid) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != '1) begin
                r_wd_cnt <= r_wd_cnt + TIMEOUT_W'(1);
            end
        end
    end

    assign core_reset   = r_core_reset;
    assign cycle        = r_cycle;
    assign timeout_fire = r_timeout_fire;
    assign sim_done     = r_sim_done;
    assign status       = r_status;

endmodule

`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
// Testbench for sim_run_ctrl: table-driven reset/timeout run plus directed
// sequences for commit keep-alive, priority, trace window and mid-run reset.
`default_nettype none

module tb_sim_run_ctrl;

    localparam int RC = 5;
    localparam int CW = 64;
    localparam int TW = 32;
`ifdef T1_TRACE_WINDOW_EN
    localparam logic c_TW = 1'b1;
`else
    localparam logic c_TW = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] cfg_dump_start = '0;
    logic [CW-1:0] cfg_dump_end = '0;
    logic [TW-1:0] cfg_timeout = '0;
    logic          commit_valid = 1'b0;
    logic          finish_req = 1'b0;
    logic          core_reset;
    logic [CW-1:0] cycle;
    logic          trace_on;
    logic          timeout_fire;
    logic          sim_done;
    logic [1:0]    status;

    sim_run_ctrl #(.RESET_CYCLES(RC), .CYCLE_W(CW), .TIMEOUT_W(TW)) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_dump_start (cfg_dump_start),
        .cfg_dump_end   (cfg_dump_end),
        .cfg_timeout    (cfg_timeout),
        .commit_valid   (commit_valid),
        .finish_req     (finish_req),
        .core_reset     (core_reset),
        .cycle          (cycle),
        .trace_on       (trace_on),
        .timeout_fire   (timeout_fire),
        .sim_done       (sim_done),
        .status         (status)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        commit;
        logic        finish;
        logic        ecr;
        logic [63:0] ecyc;
        logic        etr;
        logic        etf;
        logic        edone;
        logic [1:0]  est;
    } vec_t;

    vec_t tbl[18];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " core_reset"}, 64'(core_reset), 64'd1);
        chk({tag, " cycle"}, cycle, 64'd0);
        chk({tag, " trace_on"}, 64'(trace_on), 64'd0);
        chk({tag, " timeout_fire"}, 64'(timeout_fire), 64'd0);
        chk({tag, " sim_done"}, 64'(sim_done), 64'd0);
        chk({tag, " status"}, 64'(status), 64'd0);
    endtask

    task automatic start_run(input logic [TW-1:0] tmo, input logic [CW-1:0] ds, input logic [CW-1:0] de);
        @(negedge clock);
        reset          = 1'b0;
        commit_valid   = 1'b0;
        finish_req     = 1'b0;
        cfg_timeout    = tmo;
        cfg_dump_start = ds;
        cfg_dump_end   = de;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic vec_t mk(input logic cr, input logic [63:0] cyc, input logic tr,
                                input logic tf, input logic dn, input logic [1:0] st);
        vec_t v;
        v.commit = 1'b0;
        v.finish = 1'b0;
        v.ecr    = cr;
        v.ecyc   = cyc;
        v.etr    = tr;
        v.etf    = tf;
        v.edone  = dn;
        v.est    = st;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit tf_seen;
        bit done_early;
        bit trace_bad;

        // Reset-release with watchdog 10 and no commits: HOLD 0..5, RUN, TMO at cycle 15.
        tbl[0]  = mk(1'b1, 64'd0,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[1]  = mk(1'b1, 64'd1,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[2]  = mk(1'b1, 64'd2,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[3]  = mk(1'b1, 64'd3,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[4]  = mk(1'b1, 64'd4,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[5]  = mk(1'b1, 64'd5,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[6]  = mk(1'b0, 64'd6,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[7]  = mk(1'b0, 64'd7,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[8]  = mk(1'b0, 64'd8,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[9]  = mk(1'b0, 64'd9,  c_TW, 1'b0, 1'b0, 2'd0);
        tbl[10] = mk(1'b0, 64'd10, c_TW, 1'b0, 1'b0, 2'd0);
        tbl[11] = mk(1'b0, 64'd11, c_TW, 1'b0, 1'b0, 2'd0);
        tbl[12] = mk(1'b0, 64'd12, c_TW, 1'b0, 1'b0, 2'd0);
        tbl[13] = mk(1'b0, 64'd13, c_TW, 1'b0, 1'b0, 2'd0);
        tbl[14] = mk(1'b0, 64'd14, c_TW, 1'b0, 1'b0, 2'd0);
        tbl[15] = mk(1'b0, 64'd15, 1'b0, 1'b1, 1'b1, 2'd2);
        tbl[16] = mk(1'b1, 64'd15, 1'b0, 1'b0, 1'b1, 2'd2);
        tbl[17] = mk(1'b1, 64'd15, 1'b0, 1'b0, 1'b1, 2'd2);

        #12;
        chk_reset_vals("por");

        start_run(32'd10, 64'd0, 64'd0);
        for (int k = 0; k < 18; k++) begin
            commit_valid = tbl[k].commit;
            finish_req   = tbl[k].finish;
            tick();
            chk($sformatf("tbl%0d core_reset", k), 64'(core_reset), 64'(tbl[k].ecr));
            chk($sformatf("tbl%0d cycle", k), cycle, tbl[k].ecyc);
            chk($sformatf("tbl%0d trace_on", k), 64'(trace_on), 64'(tbl[k].etr));
            chk($sformatf("tbl%0d timeout_fire", k), 64'(timeout_fire), 64'(tbl[k].etf));
            chk($sformatf("tbl%0d sim_done", k), 64'(sim_done), 64'(tbl[k].edone));
            chk($sformatf("tbl%0d status", k), 64'(status), 64'(tbl[k].est));
        end

        // Commit lands on every would-be expiry cycle; finish at cycle 200.
        start_run(32'd10, 64'd0, 64'd0);
        tf_seen    = 1'b0;
        done_early = 1'b0;
        for (int g = 0; g < 400 && cycle != 64'd200; g++) begin
            commit_valid = (cycle % 10 == 4);
            tick();
            if (timeout_fire) tf_seen = 1'b1;
            if (sim_done) done_early = 1'b1;
        end
        commit_valid = 1'b0;
        chk("keepalive reached_200", cycle, 64'd200);
        chk("keepalive no_timeout", 64'(tf_seen), 64'd0);
        chk("keepalive not_done", 64'(done_early), 64'd0);
        finish_req = 1'b1;
        tick();
        finish_req = 1'b0;
        chk("keepalive status", 64'(status), 64'd1);
        chk("keepalive sim_done", 64'(sim_done), 64'd1);
        chk("keepalive cycle", cycle, 64'd201);
        tick();
        chk("keepalive cycle_frozen", cycle, 64'd201);

        // finish_req on the expiry edge wins over the watchdog.
        start_run(32'd10, 64'd0, 64'd0);
        for (int g = 0; g < 100 && cycle != 64'd14; g++) tick();
        finish_req = 1'b1;
        tick();
        finish_req = 1'b0;
        chk("prio status", 64'(status), 64'd1);
        chk("prio timeout_fire", 64'(timeout_fire), 64'd0);
        chk("prio cycle", cycle, 64'd15);
        tick();
        chk("prio timeout_fire_after", 64'(timeout_fire), 64'd0);
        chk("prio sim_done", 64'(sim_done), 64'd1);

        // Trace window 20..30.
        start_run(32'd0, 64'd20, 64'd30);
        trace_bad = 1'b0;
`ifdef T1_TRACE_WINDOW_EN
        for (int g = 0; g < 60 && !sim_done; g++) begin
            tick();
            if (trace_on !== ((cycle >= 64'd20) && (cycle < 64'd30))) trace_bad = 1'b1;
        end
        chk("window trace_shape", 64'(trace_bad), 64'd0);
        chk("window end_cycle", cycle, 64'd30);
        chk("window status", 64'(status), 64'd1);
        chk("window sim_done", 64'(sim_done), 64'd1);
`else
        for (int g = 0; g < 40; g++) begin
            tick();
            if (trace_on !== 1'b0) trace_bad = 1'b1;
        end
        chk("window trace_off", 64'(trace_bad), 64'd0);
        chk("window cycle", cycle, 64'd39);
        chk("window still_running", 64'(sim_done), 64'd0);
        chk("window status", 64'(status), 64'd0);
`endif

        // Async reset mid-run at cycle 50, then a rerun with a new timeout.
        start_run(32'd0, 64'd0, 64'd0);
        for (int g = 0; g < 100 && cycle != 64'd50; g++) tick();
        chk("midrun cycle", cycle, 64'd50);
        chk("midrun core_reset", 64'(core_reset), 64'd0);
        chk("midrun status", 64'(status), 64'd0);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("async");
        cfg_timeout = 32'd3;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            tick();
            if (k == 0) cfg_timeout = 32'd0;
            chk($sformatf("rerun%0d cycle", k), cycle, (k <= 8) ? 64'(k) : 64'd8);
            chk($sformatf("rerun%0d core_reset", k), 64'(core_reset), (k <= 5 || k >= 9) ? 64'd1 : 64'd0);
            chk($sformatf("rerun%0d timeout_fire", k), 64'(timeout_fire), (k == 8) ? 64'd1 : 64'd0);
            chk($sformatf("rerun%0d status", k), 64'(status), (k >= 8) ? 64'd2 : 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
